// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - state encoding and index-width helper for the serial comparator
package serial_cmp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // Bits needed to hold values 0..n-1 (at least 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparator_1bit.sv
// rtl/comparator_1bit.sv - single-bit magnitude comparator cell
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    // Pure combinational bit compare.
    always_comb begin
        gt = a & ~b;
        lt = ~a & b;
        eq = ~(a ^ b);
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - MSB-first serial magnitude compare sequencer (optional EARLY_EXIT_EN)
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int IW = clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             dec_gt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;

    comparator_1bit u_cmp (
        .a  (sa[WIDTH-1]),
        .b  (sb[WIDTH-1]),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; status outputs follow the state directly.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (idx == '0) begin
                    state_nxt = S_DONE;
                end
`ifdef EARLY_EXIT_EN
                if (!decided && !cmp_eq) begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shifting, first-difference tracking and result publication.
    // The decision is kept internally and only copied to gt/eq/lt on the
    // final SHIFT cycle, so the outputs stay clear until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            idx     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        idx     <= IW'(WIDTH - 1);
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                        gt      <= 1'b0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa << 1;
                    sb  <= sb << 1;
                    idx <= idx - 1'b1;
                    if (!decided && !cmp_eq) begin
                        decided <= 1'b1;
                        dec_gt  <= cmp_gt;
                    end
                    if (state_nxt == S_DONE) begin
                        if (decided) begin
                            gt <= dec_gt;
                            lt <= ~dec_gt;
                        end else if (!cmp_eq) begin
                            gt <= cmp_gt;
                            lt <= cmp_lt;
                        end else begin
                            eq <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
